exe_stage_div: RTL and testbench

- Execute stage of the 5-stage LoongArch pipeline, between ID and MEM.
- Latches the decoded ID bundle and computes a single-cycle ALU result.
- Runs an iterative 32-cycle divider for div/mod instructions, stalling via ready_go while it works.
- Issues the data_sram request and produces the EXE_pc/EXE_rf/EXE_load bundles consumed by MEM.

---
 rtl/exe_stage_div.sv | 167 ++++++++++++++++
 tb/tb_exe_stage_div.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_div.sv
// LoongArch EXE stage: single-cycle ALU, 32-step restoring divider that holds
// the stage via ready_go, data SRAM request generation and EXE->MEM/ID bundles.
module exe_stage_div #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        EXE_allow_in,
    input  logic        ID_EXE_valid,
    input  logic [31:0] ID_pc,
    input  logic [11:0] ID_alu_op,
    input  logic [3:0]  ID_div_op,
    input  logic [31:0] ID_src1,
    input  logic [31:0] ID_src2,
    input  logic [31:0] ID_rkd,
    input  logic [9:0]  ID_mem_ctl,
    input  logic [4:0]  ID_rf_waddr,
    input  logic        MEM_allow_in,
    output logic        EXE_MEM_valid,
    output logic [31:0] EXE_pc,
    output logic [38:0] EXE_rf,
    output logic [6:0]  EXE_load,
    output logic [38:0] EXE_fwd,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_we,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata
);
    localparam int CW = $clog2(DIV_CYCLES);

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

    logic        exe_valid_q;
    logic [31:0] pc_q, src1_q, src2_q, rkd_q;
    logic [11:0] alu_op_q;
    logic [3:0]  div_op_q;
    logic [9:0]  mem_ctl_q;
    logic [4:0]  waddr_q;

    div_state_e  div_state_q;
    logic [CW-1:0] count_q;
    logic [31:0] rem_q, quo_q, dvs_q;
    logic        s1_q, s2_q;

    logic        ready_go, is_div, div_signed, fire;
    logic [31:0] alu_res, div_res, result;

    assign is_div       = |div_op_q;
    assign ready_go     = ~is_div | (div_state_q == DIV_DONE);
    assign EXE_allow_in = ~exe_valid_q | (ready_go & MEM_allow_in);
    assign EXE_MEM_valid = exe_valid_q & ready_go;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) exe_valid_q <= 1'b0;
        else if (EXE_allow_in) exe_valid_q <= ID_EXE_valid;
    end

    // Bundle registers carry no reset; everything downstream is valid-gated.
    always_ff @(posedge clk) begin
        if (ID_EXE_valid & EXE_allow_in) begin
            pc_q      <= ID_pc;
            alu_op_q  <= ID_alu_op;
            div_op_q  <= ID_div_op;
            src1_q    <= ID_src1;
            src2_q    <= ID_src2;
            rkd_q     <= ID_rkd;
            mem_ctl_q <= ID_mem_ctl;
            waddr_q   <= ID_rf_waddr;
        end
    end

    // ALU: one-hot op select, OR-combined
    logic [31:0] add_r, sub_r, slt_r, sltu_r, sra_r;
    assign add_r  = src1_q + src2_q;
    assign sub_r  = src1_q - src2_q;
    assign slt_r  = {31'b0, $signed(src1_q) < $signed(src2_q)};
    assign sltu_r = {31'b0, src1_q < src2_q};
    assign sra_r  = $signed(src1_q) >>> src2_q[4:0];

    assign alu_res = ({32{alu_op_q[0]}}  & add_r)
                   | ({32{alu_op_q[1]}}  & sub_r)
                   | ({32{alu_op_q[2]}}  & slt_r)
                   | ({32{alu_op_q[3]}}  & sltu_r)
                   | ({32{alu_op_q[4]}}  & (src1_q & src2_q))
                   | ({32{alu_op_q[5]}}  & ~(src1_q | src2_q))
                   | ({32{alu_op_q[6]}}  & (src1_q | src2_q))
                   | ({32{alu_op_q[7]}}  & (src1_q ^ src2_q))
                   | ({32{alu_op_q[8]}}  & (src1_q << src2_q[4:0]))
                   | ({32{alu_op_q[9]}}  & (src1_q >> src2_q[4:0]))
                   | ({32{alu_op_q[10]}} & sra_r)
                   | ({32{alu_op_q[11]}} & src2_q);

    // Divider: magnitudes in, sign fix applied on the held DONE value
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [31:0] rem_sub, abs1, abs2;
    assign div_signed = div_op_q[0] | div_op_q[1];
    assign abs1    = (div_signed & src1_q[31]) ? -src1_q : src1_q;
    assign abs2    = (div_signed & src2_q[31]) ? -src2_q : src2_q;
    assign rem_sh  = {rem_q, quo_q[31]};
    assign rem_ge  = rem_sh >= {1'b0, dvs_q};
    assign rem_sub = rem_sh[31:0] - dvs_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_state_q <= DIV_IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
        end else begin
            case (div_state_q)
                DIV_IDLE: if (exe_valid_q & is_div) begin
                    div_state_q <= DIV_BUSY;
                    count_q     <= '0;
                    rem_q       <= '0;
                    quo_q       <= abs1;
                    dvs_q       <= abs2;
                    s1_q        <= div_signed & src1_q[31];
                    s2_q        <= div_signed & src2_q[31];
                end
                DIV_BUSY: begin
                    rem_q   <= rem_ge ? rem_sub : rem_sh[31:0];
                    quo_q   <= {quo_q[30:0], rem_ge};
                    count_q <= count_q + CW'(1);
                    if (count_q == CW'(DIV_CYCLES - 1)) div_state_q <= DIV_DONE;
                end
                DIV_DONE: if (MEM_allow_in) div_state_q <= DIV_IDLE;
                default:  div_state_q <= DIV_IDLE;
            endcase
        end
    end

    logic [31:0] quo_fix, rem_fix;
    assign quo_fix = (s1_q ^ s2_q) ? -quo_q : quo_q;
    assign rem_fix = s1_q ? -rem_q : rem_q;
    assign div_res = (div_op_q[1] | div_op_q[3]) ? rem_fix : quo_fix;
    assign result  = is_div ? div_res : alu_res;

    // Data SRAM: one request, issued only on the cycle the stage hands off
    logic       st_w, st_h, st_b;
    logic [3:0] we_raw;
    assign st_w = mem_ctl_q[7];
    assign st_h = mem_ctl_q[6];
    assign st_b = mem_ctl_q[5];
    assign fire = exe_valid_q & ready_go & MEM_allow_in;

    always_comb begin
        we_raw = 4'b0000;
        if (st_w)      we_raw = 4'b1111;
        else if (st_h) we_raw = result[1] ? 4'b1100 : 4'b0011;
        else if (st_b) we_raw = 4'b0001 << result[1:0];
    end

    assign data_sram_en    = fire & (|mem_ctl_q[7:0]);
    assign data_sram_we    = fire ? we_raw : 4'b0000;
    assign data_sram_addr  = result;
    assign data_sram_wdata = st_b ? {4{rkd_q[7:0]}} :
                             st_h ? {2{rkd_q[15:0]}} : rkd_q;

    assign EXE_pc   = pc_q;
    assign EXE_rf   = {mem_ctl_q[9], mem_ctl_q[8], waddr_q, result};
    assign EXE_load = {result[1:0], mem_ctl_q[4:0]};
    assign EXE_fwd  = {mem_ctl_q[9], mem_ctl_q[8] & exe_valid_q, waddr_q, result};
endmodule

// File: tb/tb_exe_stage_div.sv
// Scoreboard bench for exe_stage_div: driver pushes expected results computed
// by a plain-arithmetic model; a negedge monitor checks hand-offs and latency.
module tb_exe_stage_div;
    logic        clk = 0, rst = 0;
    logic        EXE_allow_in, ID_EXE_valid, MEM_allow_in, EXE_MEM_valid;
    logic [31:0] ID_pc, ID_src1, ID_src2, ID_rkd, EXE_pc;
    logic [11:0] ID_alu_op;
    logic [3:0]  ID_div_op, data_sram_we;
    logic [9:0]  ID_mem_ctl;
    logic [4:0]  ID_rf_waddr;
    logic [38:0] EXE_rf, EXE_fwd;
    logic [6:0]  EXE_load;
    logic        data_sram_en;
    logic [31:0] data_sram_addr, data_sram_wdata;

    exe_stage_div dut (
        .clk(clk), .rst(rst), .EXE_allow_in(EXE_allow_in), .ID_EXE_valid(ID_EXE_valid),
        .ID_pc(ID_pc), .ID_alu_op(ID_alu_op), .ID_div_op(ID_div_op), .ID_src1(ID_src1),
        .ID_src2(ID_src2), .ID_rkd(ID_rkd), .ID_mem_ctl(ID_mem_ctl), .ID_rf_waddr(ID_rf_waddr),
        .MEM_allow_in(MEM_allow_in), .EXE_MEM_valid(EXE_MEM_valid), .EXE_pc(EXE_pc),
        .EXE_rf(EXE_rf), .EXE_load(EXE_load), .EXE_fwd(EXE_fwd), .data_sram_en(data_sram_en),
        .data_sram_we(data_sram_we), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc, a, b, rkd;
        logic [11:0] alu;
        logic [3:0]  div;
        logic [9:0]  mc;
        logic [4:0]  wa;
    } ins_t;
    typedef struct { ins_t i; int load_cyc; } exp_t;

    exp_t q[$];
    int   tests = 0, fails = 0, cyc = 0, stall_pct = 0, hold_cnt = 0;
    bit   head_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: division rules written directly as integer arithmetic
    function automatic logic [31:0] ref_res(input ins_t x);
        int sa, sb;
        logic [31:0] qo, rm;
        if (x.div != 0) begin
            if (x.div[2] | x.div[3]) begin
                if (x.b == 0) begin qo = 32'hFFFFFFFF; rm = x.a; end
                else begin qo = x.a / x.b; rm = x.a % x.b; end
            end else begin
                sa = x.a; sb = x.b;
                if (sb == 0) begin qo = (sa < 0) ? 32'd1 : 32'hFFFFFFFF; rm = x.a; end
                else if (x.a == 32'h80000000 && sb == -1) begin qo = 32'h80000000; rm = 0; end
                else begin qo = sa / sb; rm = sa % sb; end
            end
            return (x.div[1] | x.div[3]) ? rm : qo;
        end
        case (1'b1)
            x.alu[0]:  return x.a + x.b;
            x.alu[1]:  return x.a - x.b;
            x.alu[2]:  return (int'(x.a) < int'(x.b)) ? 32'd1 : 32'd0;
            x.alu[3]:  return (x.a < x.b) ? 32'd1 : 32'd0;
            x.alu[4]:  return x.a & x.b;
            x.alu[5]:  return ~(x.a | x.b);
            x.alu[6]:  return x.a | x.b;
            x.alu[7]:  return x.a ^ x.b;
            x.alu[8]:  return x.a << x.b[4:0];
            x.alu[9]:  return x.a >> x.b[4:0];
            x.alu[10]: return int'(x.a) >>> x.b[4:0];
            x.alu[11]: return x.b;
            default:   return 32'd0;
        endcase
    endfunction

    // Monitor: compare the head entry on the cycle it is handed to MEM
    initial forever begin
        @(negedge clk);
        if (rst && q.size() > 0 && q[0].load_cyc <= cyc) begin
            exp_t e;
            logic [31:0] r;
            logic [3:0]  we;
            logic [31:0] wd;
            int   lat;
            e = q[0];
            lat = (e.i.div != 0) ? 33 : 0;
            r = ref_res(e.i);
            if (!head_seen && EXE_MEM_valid) begin
                head_seen = 1;
                chk("latency", 64'(cyc - e.load_cyc), 64'(lat));
            end
            if (e.i.div != 0 && cyc - e.load_cyc < 33) chk("stall_allow_in", EXE_allow_in, 0);
            if (EXE_MEM_valid && MEM_allow_in) begin
                we = e.i.mc[7] ? 4'b1111 : e.i.mc[6] ? (r[1] ? 4'b1100 : 4'b0011) :
                     e.i.mc[5] ? (4'b0001 << r[1:0]) : 4'b0000;
                wd = e.i.mc[5] ? {4{e.i.rkd[7:0]}} : e.i.mc[6] ? {2{e.i.rkd[15:0]}} : e.i.rkd;
                chk("pc", EXE_pc, e.i.pc);
                chk("rf", EXE_rf, {e.i.mc[9], e.i.mc[8], e.i.wa, r});
                chk("load", EXE_load, {r[1:0], e.i.mc[4:0]});
                chk("fwd", EXE_fwd, {e.i.mc[9], e.i.mc[8], e.i.wa, r});
                chk("sram_en", data_sram_en, |e.i.mc[7:0]);
                chk("sram_we", data_sram_we, we);
                chk("sram_addr", data_sram_addr, r);
                chk("sram_wdata", data_sram_wdata, wd);
                void'(q.pop_front());
                head_seen = 0;
            end else begin
                chk("sram_en_stall", data_sram_en, 0);
                chk("sram_we_stall", data_sram_we, 0);
            end
        end else if (rst) begin
            chk("idle_valid", EXE_MEM_valid, 0);
            chk("idle_sram_en", data_sram_en, 0);
        end
    end

    // MEM back-pressure: forced hold cycles, else random stalls
    initial begin
        MEM_allow_in = 1;
        forever begin
            @(posedge clk); #2;
            if (hold_cnt > 0) begin MEM_allow_in = 0; hold_cnt--; end
            else MEM_allow_in = ($urandom_range(99) >= stall_pct);
        end
    end

    task automatic idle(input int n);
        ID_EXE_valid = 0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic issue(input ins_t x, output int waits);
        bit ok = 0;
        ID_pc = x.pc; ID_alu_op = x.alu; ID_div_op = x.div; ID_src1 = x.a; ID_src2 = x.b;
        ID_rkd = x.rkd; ID_mem_ctl = x.mc; ID_rf_waddr = x.wa; ID_EXE_valid = 1;
        waits = 0;
        while (!ok && waits < 300) begin
            @(negedge clk);
            if (EXE_allow_in) begin
                exp_t e;
                e.i = x; e.load_cyc = cyc + 1;
                q.push_back(e);
                ok = 1;
            end else waits++;
            @(posedge clk); #1;
        end
        ID_EXE_valid = 0;
        if (!ok) chk("issue_timeout", 0, 1);
    endtask

    function automatic ins_t mk(input logic [11:0] alu, input logic [3:0] dv,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] rkd, input logic [9:0] mc);
        ins_t x;
        x.pc = $urandom & 32'hFFFFFFFC; x.alu = alu; x.div = dv; x.a = a; x.b = b;
        x.rkd = rkd; x.mc = mc; x.wa = 5'($urandom_range(31));
        return x;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(5))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(15));
            4: return -32'($urandom_range(15));
            default: return $urandom;
        endcase
    endfunction

    function automatic ins_t rnd_ins();
        ins_t x;
        int k;
        logic [9:0] mc;
        logic [11:0] alu;
        logic [3:0] dv;
        alu = 0; dv = 0; mc = 10'h100;
        if ($urandom_range(3) == 0) dv = 4'b0001 << $urandom_range(3);
        else begin
            alu = 12'b1 << $urandom_range(11);
            k = $urandom_range(9);
            if (k < 5)      mc = (10'b1 << k) | 10'h300;
            else if (k < 8) mc = 10'b1 << k;
            else            mc = {1'b0, 1'($urandom_range(1)), 8'b0};
        end
        x = mk(alu, dv, rnd_val(), rnd_val(), $urandom, mc);
        return x;
    endfunction

    localparam logic [11:0] ADD = 12'h001, SUB = 12'h002;
    localparam logic [3:0]  DIVW = 4'b0001, MODW = 4'b0010, DIVWU = 4'b0100, MODWU = 4'b1000;

    initial begin
        int w;
        ID_EXE_valid = 0; ID_pc = 0; ID_alu_op = 0; ID_div_op = 0; ID_src1 = 0; ID_src2 = 0;
        ID_rkd = 0; ID_mem_ctl = 0; ID_rf_waddr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_exe_mem_valid", EXE_MEM_valid, 0);
        chk("rst_allow_in", EXE_allow_in, 1);
        chk("rst_sram_en", data_sram_en, 0);
        chk("rst_sram_we", data_sram_we, 0);
        chk("rst_fwd_we", EXE_fwd[37], 0);
        @(posedge clk); #1 rst = 1;
        idle(2);

        // back-to-back ALU with no back-pressure
        issue(mk(ADD, 0, 5, 7, 0, 10'h100), w);
        issue(mk(SUB, 0, 3, 9, 0, 10'h100), w);
        chk("b2b_allow_in", w, 0);
        idle(2);
        // stores
        issue(mk(ADD, 0, 32'h1000, 1, 32'h000000AB, 10'h020), w);
        issue(mk(ADD, 0, 32'h1000, 2, 32'h1234ABCD, 10'h040), w);
        // signed divide/modulo and corner cases
        issue(mk(0, DIVW, -7, 2, 0, 10'h100), w);
        issue(mk(0, MODW, -7, 2, 0, 10'h100), w);
        issue(mk(0, DIVWU, 10, 0, 0, 10'h100), w);
        issue(mk(0, MODWU, 10, 0, 0, 10'h100), w);
        issue(mk(0, DIVW, 32'h80000000, 32'hFFFFFFFF, 0, 10'h100), w);
        idle(2);
        // load under MEM back-pressure
        hold_cnt = 4;
        issue(mk(ADD, 0, 32'h2000, 3, 0, 10'h308), w);
        idle(6);

        stall_pct = 30;
        for (int n = 0; n < 60; n++) begin
            issue(rnd_ins(), w);
            if ($urandom_range(3) == 0) idle($urandom_range(3));
        end
        stall_pct = 0;
        for (int n = 0; n < 300 && q.size() > 0; n++) begin @(posedge clk); #1; end
        chk("drain", q.size(), 0);

        // asynchronous reset in the middle of a divide
        issue(mk(0, DIVW, 100, 7, 0, 10'h100), w);
        repeat (9) @(posedge clk);
        #2 rst = 0;
        #1;
        q.delete(); head_seen = 0;
        chk("mid_rst_exe_mem_valid", EXE_MEM_valid, 0);
        chk("mid_rst_allow_in", EXE_allow_in, 1);
        chk("mid_rst_fwd_we", EXE_fwd[37], 0);
        @(posedge clk); #1 rst = 1;
        issue(mk(ADD, 0, 40, 2, 0, 10'h100), w);
        issue(mk(0, MODW, 100, -7, 0, 10'h100), w);
        for (int n = 0; n < 100 && q.size() > 0; n++) begin @(posedge clk); #1; end
        chk("final_drain", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end
endmodule
